qdec_lb_syntax_reader: RTL and testbench
========================================

// Module: qdec_lb_syntax_reader
// PURPOSE
//  Reader end of the CABAC line-buffer interface (lb_raddr/lb_re/lb_dout).
//  On each ctu_done pulse, fetches the decoded CTU syntax bytes from the line buffer.
//  Bytes come back with 1-cycle read latency and leave as a vld/rdy byte stream to the
//  downstream reconstruction stage, with a last marker on the final byte of each CTU.
//  Sits between qdec_cabac and the IQ/IT front end.
// PARAMETERS
//  ADDR_W   12  line-buffer address width; addresses wrap modulo 2**ADDR_W
//  BUF_DEP  2   output buffer entries (>=2; covers read latency at full rate)
// PORTS
//  clk          in   1       clock
//  rst          in   1       synchronous reset, active-high
//  ctu_done     in   1       1-cycle pulse: CTU syntax ready in line buffer
//  ctu_base     in   ADDR_W  start address of CTU, sampled on ctu_done
//  ctu_len      in   ADDR_W  byte count of CTU, sampled on ctu_done; 0 = 2**ADDR_W bytes
//  lb_raddr     out  ADDR_W  line-buffer read address
//  lb_re        out  1       line-buffer read enable; lb_dout valid next cycle
//  lb_dout      in   8       line-buffer read data
//  dout         out  8       syntax byte
//  dout_vld     out  1       dout valid
//  dout_rdy     in   1       downstream ready
//  dout_last    out  1       final byte of current CTU (qualified by dout_vld)
//  busy         out  1       CTU transfer in progress
//  overrun_err  out  1       sticky: ctu_done received while busy
//  ctu_cnt      out  16      completed-CTU count (see CONFIGURATION)
// BEHAVIOUR
//  Reset values: all outputs 0; FSM=IDLE; buffer empty.
//   - Reset mid-transfer aborts the transfer; no byte is emitted the following cycle.
//  FSM states:
//   - IDLE: ctu_done -> latch base/len, rd_ptr=base, remain=len, busy=1 -> READ.
//   - READ: lb_re=1 when (buf_count + inflight) < BUF_DEP and remain!=0.
//     On each read: lb_raddr=rd_ptr, rd_ptr+=1 (wraps 2**ADDR_W-1 -> 0), remain-=1.
//     remain reaching 0 -> DRAIN.
//   - DRAIN: no reads. Buffer empty with nothing in flight -> IDLE, busy=0.
//  lb_dout is written into the buffer the cycle after lb_re, with its last flag.
//   - last flag is set for the read issued when remain==1.
//  Transfer: a byte moves when dout_vld & dout_rdy.
//   - dout/dout_last hold stable while dout_vld & !dout_rdy.
//   - dout_vld never drops without a transfer.
//  Throughput: 1 byte/cycle sustained with dout_rdy=1.
//   - First dout_vld 2 cycles after ctu_done (cycle n+1 read, n+2 data).
//  Simultaneous push and pop in one cycle: both happen, count unchanged. No push when full.
//  ctu_done while busy: ignored, overrun_err=1 (cleared only by rst).
//  ctu_done on the same cycle busy falls (DRAIN->IDLE): ignored, and counts as overrun.
//  busy stays 1 until the last byte has transferred.
// CONFIGURATION
//  QDEC_LB_SYNRD_STATS_EN defined:
//   - ctu_cnt increments on each dout_last transfer.
//   - 16-bit, wraps 0xFFFF -> 0; reset 0.
//  Undefined: ctu_cnt tied to 0, no counter logic.
// TESTING
//  1. ctu_done, base=0x010, len=4, rdy=1:
//     lb_raddr 0x010..0x013 on consecutive cycles; 4 bytes out in order, last on 4th;
//     busy falls after the 4th transfer.
//  2. base=0xFFE, len=4:
//     addresses 0xFFE, 0xFFF, 0x000, 0x001; data matches the LB model.
//  3. len=16, dout_rdy toggling 1-on/2-off:
//     no byte lost or duplicated; dout stable while stalled; at most BUF_DEP reads outstanding.
//  4. Second ctu_done while busy:
//     ignored, overrun_err=1 and sticky; the first CTU completes intact.
//  5. rst asserted mid-transfer (after 3 of 8 bytes):
//     next cycle all outputs 0; a new ctu_done starts a clean transfer.
//  6. With QDEC_LB_SYNRD_STATS_EN, 3 back-to-back CTUs of len=1:
//     ctu_cnt=3. Without the macro: ctu_cnt stays 0.

Source files
------------

// File: rtl/qdec_lb_syntax_reader.sv
// qdec_lb_syntax_reader: fetches one CTU worth of syntax bytes from the CABAC
// line buffer after each ctu_done pulse. It then streams them downstream as a
// vld/rdy byte stream and marks the final byte of each CTU with dout_last.
//
// Optional feature: define QDEC_LB_SYNRD_STATS_EN to enable the completed-CTU
// counter on ctu_cnt. When the macro is undefined, ctu_cnt is tied to 0.
//
// The output buffer is fall-through. When it is empty, a byte returning from the
// line buffer is presented directly on dout. This keeps the first-byte latency at
// two cycles after ctu_done.
`timescale 1ns/1ps
module qdec_lb_syntax_reader #(
    parameter int ADDR_W  = 12,
    parameter int BUF_DEP = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctu_done,
    input  logic [ADDR_W-1:0] ctu_base,
    input  logic [ADDR_W-1:0] ctu_len,
    output logic [ADDR_W-1:0] lb_raddr,
    output logic              lb_re,
    input  logic [7:0]        lb_dout,
    output logic [7:0]        dout,
    output logic              dout_vld,
    input  logic              dout_rdy,
    output logic              dout_last,
    output logic              busy,
    output logic              overrun_err,
    output logic [15:0]       ctu_cnt
);
    localparam int PW = (BUF_DEP > 1) ? $clog2(BUF_DEP) : 1;
    localparam int CW = $clog2(BUF_DEP + 1);
    localparam logic [ADDR_W:0] REM_ONE = {{ADDR_W{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   remain_reg;        // one extra bit so len=0 can mean 2**ADDR_W
    logic              inflight_reg;      // read issued last cycle; data on lb_dout now
    logic              inflight_last_reg; // that read was the final byte of the CTU
    logic [7:0]        buf_data_reg [BUF_DEP];
    logic              buf_last_reg [BUF_DEP];
    logic [PW-1:0]     wr_idx_reg, rd_idx_reg;
    logic [CW-1:0]     count_reg, count_next;
    logic              overrun_reg;

    logic              empty, pop, push, buf_pop;
    logic [CW:0]       occupancy;

    // Buffer index advance with wrap at BUF_DEP (which need not be a power of two)
    function automatic logic [PW-1:0] idx_inc(input logic [PW-1:0] idx);
        return (idx == PW'(BUF_DEP - 1)) ? '0 : idx + 1'b1;
    endfunction

    // Stream-side handshake, bypass path and read credit
    always_comb begin
        empty      = (count_reg == '0);
        dout_vld   = !empty || inflight_reg;
        pop        = dout_vld && dout_rdy;
        // A returning byte is only stored if it was not consumed straight from the bypass
        push       = inflight_reg && !(empty && pop);
        buf_pop    = pop && !empty;
        count_next = count_reg + CW'(push) - CW'(buf_pop);
        occupancy  = {1'b0, count_reg} + {{CW{1'b0}}, inflight_reg};
        dout       = 8'h00;
        dout_last  = 1'b0;
        if (!empty) begin
            dout      = buf_data_reg[rd_idx_reg];
            dout_last = buf_last_reg[rd_idx_reg];
        end else if (inflight_reg) begin
            dout      = lb_dout;
            dout_last = inflight_last_reg;
        end
        lb_re    = (state_reg == READ) && (remain_reg != '0) &&
                   (occupancy < (CW+1)'(BUF_DEP));
        lb_raddr = rd_ptr_reg;
        busy     = (state_reg != IDLE);
    end

    // Next-state logic: READ until the final read issues, DRAIN until the buffer empties
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ctu_done) state_next = READ;
            READ:    if (lb_re && remain_reg == REM_ONE) state_next = DRAIN;
            DRAIN:   if (count_next == '0) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control registers: FSM, read pointer, remaining count, in-flight tracking, buffer pointers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg         <= IDLE;
            rd_ptr_reg        <= '0;
            remain_reg        <= '0;
            inflight_reg      <= 1'b0;
            inflight_last_reg <= 1'b0;
            wr_idx_reg        <= '0;
            rd_idx_reg        <= '0;
            count_reg         <= '0;
            overrun_reg       <= 1'b0;
        end else begin
            state_reg         <= state_next;
            inflight_reg      <= lb_re;
            inflight_last_reg <= lb_re && (remain_reg == REM_ONE);
            count_reg         <= count_next;
            if (state_reg == IDLE && ctu_done) begin
                rd_ptr_reg <= ctu_base;
                remain_reg <= (ctu_len == '0) ? {1'b1, {ADDR_W{1'b0}}} : {1'b0, ctu_len};
            end else if (lb_re) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
                remain_reg <= remain_reg - 1'b1;
            end
            if (ctu_done && state_reg != IDLE) overrun_reg <= 1'b1;
            if (push)    wr_idx_reg <= idx_inc(wr_idx_reg);
            if (buf_pop) rd_idx_reg <= idx_inc(rd_idx_reg);
        end
    end

    // Buffer storage: one write port per entry, selected by the write index
    for (genvar gi = 0; gi < BUF_DEP; gi++) begin : g_buf
        always_ff @(posedge clk) begin
            if (push && wr_idx_reg == PW'(gi)) begin
                buf_data_reg[gi] <= lb_dout;
                buf_last_reg[gi] <= inflight_last_reg;
            end
        end
    end

    assign overrun_err = overrun_reg;

`ifdef QDEC_LB_SYNRD_STATS_EN
    logic [15:0] ctu_cnt_reg;
    // Count CTUs whose final byte has been handed downstream
    always_ff @(posedge clk) begin
        if (rst)                   ctu_cnt_reg <= '0;
        else if (pop && dout_last) ctu_cnt_reg <= ctu_cnt_reg + 1'b1;
    end
    assign ctu_cnt = ctu_cnt_reg;
`else
    assign ctu_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_qdec_lb_syntax_reader.sv
// Testbench for qdec_lb_syntax_reader. It uses a line-buffer memory model, a
// scoreboard of expected read addresses and bytes derived from each accepted
// ctu_done, and per-cycle protocol checks. Literal checks pin the reference
// behaviour.
`timescale 1ns/1ps
module tb_qdec_lb_syntax_reader;
    localparam int ADDR_W  = 12;
    localparam int BUF_DEP = 2;
    localparam int DEPTH   = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ctu_done = 1'b0;
    logic [ADDR_W-1:0] ctu_base = '0;
    logic [ADDR_W-1:0] ctu_len = '0;
    logic [ADDR_W-1:0] lb_raddr;
    logic              lb_re;
    logic [7:0]        lb_dout = 8'h00;
    logic [7:0]        dout;
    logic              dout_vld;
    logic              dout_rdy = 1'b1;
    logic              dout_last;
    logic              busy;
    logic              overrun_err;
    logic [15:0]       ctu_cnt;

    qdec_lb_syntax_reader #(.ADDR_W(ADDR_W), .BUF_DEP(BUF_DEP)) dut (
        .clk(clk), .rst(rst), .ctu_done(ctu_done), .ctu_base(ctu_base), .ctu_len(ctu_len),
        .lb_raddr(lb_raddr), .lb_re(lb_re), .lb_dout(lb_dout),
        .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .dout_last(dout_last),
        .busy(busy), .overrun_err(overrun_err), .ctu_cnt(ctu_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Line-buffer model: registered read, one cycle latency
    logic [7:0] lb_mem [DEPTH];
    always @(posedge clk) if (lb_re) lb_dout <= lb_mem[lb_raddr];

    // Downstream ready pattern generator
    int rdy_mode = 0;
    int rdy_phase = 0;
    initial begin
        forever begin
            @(posedge clk); #1;
            rdy_phase++;
            case (rdy_mode)
                0: dout_rdy = 1'b1;
                1: dout_rdy = (rdy_phase % 3 == 0);
                default: dout_rdy = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Reference model state
    logic [ADDR_W-1:0] addr_q [$];
    logic [8:0]        exp_q  [$];   // {last, data}
    logic [ADDR_W-1:0] rd_log [$];
    logic              exp_busy = 1'b0;
    logic              exp_ovr  = 1'b0;
    logic [15:0]       exp_cnt  = '0;
    int                outstanding = 0;
    int                xfer_cnt = 0;
    logic              prev_stall = 1'b0;
    logic [7:0]        prev_dout;
    logic              prev_last;

    // Per-cycle compare against the model, sampled mid-cycle
    always @(negedge clk) begin
        if (rst) begin
            addr_q.delete(); exp_q.delete();
            exp_busy = 1'b0; exp_ovr = 1'b0; exp_cnt = '0;
            outstanding = 0; prev_stall = 1'b0;
        end else begin
            logic cur_busy;
            logic [8:0] e;
            cur_busy = exp_busy;
            chk("busy", 32'(busy), 32'(exp_busy));
            chk("overrun_err", 32'(overrun_err), 32'(exp_ovr));
            chk("ctu_cnt", 32'(ctu_cnt), 32'(exp_cnt));
            if (prev_stall) begin
                chk("hold_vld", 32'(dout_vld), 32'd1);
                chk("hold_dout", 32'(dout), 32'(prev_dout));
                chk("hold_last", 32'(dout_last), 32'(prev_last));
            end
            if (lb_re) begin
                rd_log.push_back(lb_raddr);
                outstanding++;
                if (addr_q.size() == 0) chk("spurious_read", 32'(lb_raddr), 32'hFFFF_FFFF);
                else chk("lb_raddr", 32'(lb_raddr), 32'(addr_q.pop_front()));
                chk("outstanding_le_dep", 32'(outstanding <= BUF_DEP), 32'd1);
            end
            if (dout_vld && dout_rdy) begin
                outstanding--;
                xfer_cnt++;
                if (exp_q.size() == 0) chk("spurious_byte", {23'd0, dout_last, dout}, 32'hFFFF_FFFF);
                else begin
                    e = exp_q.pop_front();
                    chk("dout", 32'(dout), 32'(e[7:0]));
                    chk("dout_last", 32'(dout_last), 32'(e[8]));
                    if (e[8]) begin
                        exp_busy = 1'b0;
`ifdef QDEC_LB_SYNRD_STATS_EN
                        exp_cnt = exp_cnt + 16'd1;
`endif
                    end
                end
            end
            if (ctu_done) begin
                if (cur_busy) exp_ovr = 1'b1;
                else begin
                    int n;
                    logic [ADDR_W-1:0] a;
                    n = (ctu_len == 0) ? DEPTH : int'(ctu_len);
                    for (int i = 0; i < n; i++) begin
                        a = ADDR_W'((int'(ctu_base) + i) % DEPTH);
                        addr_q.push_back(a);
                        exp_q.push_back({(i == n - 1), lb_mem[a]});
                    end
                    exp_busy = 1'b1;
                end
            end
            prev_stall = dout_vld && !dout_rdy;
            prev_dout  = dout;
            prev_last  = dout_last;
        end
    end

    task automatic pulse_ctu(input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] l);
        @(posedge clk); #1;
        ctu_done = 1'b1; ctu_base = b; ctu_len = l;
        @(posedge clk); #1;
        ctu_done = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string nm);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= budget) chk({nm, "_timeout"}, 32'(n), 32'(budget - 1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        #1;
    endtask

    task automatic check_all_zero(input string nm);
        chk({nm, "_dout"}, 32'(dout), 32'd0);
        chk({nm, "_vld"}, 32'(dout_vld), 32'd0);
        chk({nm, "_last"}, 32'(dout_last), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd0);
        chk({nm, "_ovr"}, 32'(overrun_err), 32'd0);
        chk({nm, "_re"}, 32'(lb_re), 32'd0);
        chk({nm, "_raddr"}, 32'(lb_raddr), 32'd0);
        chk({nm, "_cnt"}, 32'(ctu_cnt), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        logic [ADDR_W-1:0] exp_a [4];
        int start_log, start_x, n;
        for (int i = 0; i < DEPTH; i++) lb_mem[i] = 8'($urandom);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_all_zero("reset");

        // T1: base 0x010, len 4, full rate; literal latency checks
        @(posedge clk); #1;
        ctu_done = 1'b1; ctu_base = 12'h010; ctu_len = 12'd4;
        @(posedge clk); #1;
        ctu_done = 1'b0;
        #1;
        chk("t1_first_re", 32'(lb_re), 32'd1);
        chk("t1_first_addr", 32'(lb_raddr), 32'h010);
        @(posedge clk); #2;
        chk("t1_first_vld", 32'(dout_vld), 32'd1);
        chk("t1_first_byte", 32'(dout), 32'(lb_mem[16]));
        wait_idle(50, "t1");
        $display("[TB] T1 base=0x010 len=4 done");

        // T2: address wrap
        start_log = rd_log.size();
        pulse_ctu(12'hFFE, 12'd4);
        wait_idle(50, "t2");
        exp_a[0] = 12'hFFE; exp_a[1] = 12'hFFF; exp_a[2] = 12'h000; exp_a[3] = 12'h001;
        chk("t2_nreads", 32'(rd_log.size() - start_log), 32'd4);
        for (int i = 0; i < 4; i++)
            if (start_log + i < rd_log.size())
                chk("t2_wrap_addr", 32'(rd_log[start_log + i]), 32'(exp_a[i]));
        $display("[TB] T2 base=0xFFE len=4 wrap done");

        // T3: stalled downstream, 1-on/2-off
        rdy_mode = 1;
        pulse_ctu(12'h200, 12'd16);
        wait_idle(200, "t3");
        rdy_mode = 0;
        $display("[TB] T3 len=16 stalled done");

        // T4: overrun while busy
        pulse_ctu(12'h300, 12'd8);
        @(posedge clk); #1;
        pulse_ctu(12'h400, 12'd5);
        #1 chk("t4_ovr_set", 32'(overrun_err), 32'd1);
        wait_idle(100, "t4");
        chk("t4_ovr_sticky", 32'(overrun_err), 32'd1);
        $display("[TB] T4 overrun done");

        // T5: reset after 3 of 8 bytes
        do_reset();
        start_x = xfer_cnt;
        pulse_ctu(12'h500, 12'd8);
        n = 0;
        while (xfer_cnt - start_x < 3 && n < 50) begin @(posedge clk); #2; n++; end
        chk("t5_reach3", 32'(xfer_cnt - start_x >= 3), 32'd1);
        do_reset();
        check_all_zero("t5_after_rst");
        pulse_ctu(12'h600, 12'd5);
        wait_idle(50, "t5_restart");
        $display("[TB] T5 mid-transfer reset done");

        // T6: three len=1 CTUs
        do_reset();
        for (int i = 0; i < 3; i++) begin
            pulse_ctu(12'h700 + 12'(i), 12'd1);
            wait_idle(20, "t6");
        end
`ifdef QDEC_LB_SYNRD_STATS_EN
        chk("t6_ctu_cnt", 32'(ctu_cnt), 32'd3);
`else
        chk("t6_ctu_cnt", 32'(ctu_cnt), 32'd0);
`endif
        $display("[TB] T6 three len=1 CTUs done");

        // Random phase: random base/len, random ready, occasional overrun attempt
        rdy_mode = 2;
        for (int k = 0; k < 25; k++) begin
            logic [ADDR_W-1:0] b, l;
            b = 12'($urandom);
            l = (k == 12) ? 12'd0 : 12'($urandom_range(1, 24));
            pulse_ctu(b, l);
            if ($urandom_range(0, 3) == 0) pulse_ctu(12'($urandom), 12'd3);
            wait_idle(20000, "rand");
            $display("[TB] random CTU %0d base=0x%03h len=%0d done", k, b, l);
        end
        chk("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
